ray_march_ctrl: RTL and testbench
=================================

RAY_MARCH_CTRL -- requirements
Module: ray_march_ctrl

Interface
REQ-001 SHALL have parameter MAX_STEP, default 1023, meaning the last step index issued per ray (range 0..1023).
REQ-002 SHALL have parameter MAP_LAT, default 1, meaning the cycles from a position sample to the `hit` input from the maze-map lookup; total loop latency L = 1 + MAP_LAT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: ray request valid.
REQ-006 SHALL have port ready, output, 1 bit: ray request accept; high only in IDLE.
REQ-007 SHALL have ports ori_x/ori_y/ori_z, input, 11 bits signed each: ray origin, sampled on accept.
REQ-008 SHALL have ports dir_x/dir_y/dir_z, input, 10 bits signed each (*2^8): ray direction, sampled on accept.
REQ-009 SHALL have ports ray_ori_x/y/z (11 bits signed) and ray_dir_x/y/z (10 bits signed), output: latched ray held stable to the position datapath until the next accept.
REQ-010 SHALL have port step_p, output, 19 bits: step index driven to the position datapath.
REQ-011 SHALL have port step_valid, output, 1 bit: step_p is a live sample this cycle.
REQ-012 SHALL have port hit, input, 1 bit: wall hit for the sample issued L cycles earlier.
REQ-013 SHALL have port res_valid, output, 1 bit: result available.
REQ-014 SHALL have port res_ack, input, 1 bit: result consumed.
REQ-015 SHALL have port res_hit, output, 1 bit: wall found.
REQ-016 SHALL have port res_dist, output, 10 bits: step index of the first hit; 10'h3FF on miss.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-018 SHALL, in IDLE with start=1 (accept cycle T), latch ori/dir and enter ISSUE; step_valid=1 with step_p=0 at T+1.
REQ-019 SHALL, in ISSUE, increment step_p by 1 every cycle with step_valid=1; bits 18:10 are always 0.
REQ-020 SHALL carry a tag pipeline of depth L holding (valid, step index) per issued step, shifted every cycle.
REQ-021 SHALL ignore hit whenever the tag at the pipeline output is invalid.
REQ-022 SHALL, on hit with a valid output tag in ISSUE or DRAIN, set res_dist to that tag's index and res_hit=1, clear all tag valids, deassert step_valid, and enter DONE in the same edge.
REQ-023 SHALL, after issuing MAX_STEP without a hit, enter DRAIN with step_valid=0.
REQ-024 SHALL, in DRAIN, enter DONE with res_hit=0 and res_dist=10'h3FF once the tag pipeline is empty and no hit is taken.
REQ-025 SHALL give priority to a hit over the end-of-issue transition in the same cycle; any step issued in that cycle is discarded.
REQ-026 SHALL hold res_valid=1 and res_hit/res_dist stable in DONE until res_ack=1, then enter IDLE on the next edge.
REQ-027 SHALL ignore start outside IDLE.
REQ-028 SHALL allow back-to-back rays: stale hits from a previous ray meet invalid tags and are dropped.

Reset
REQ-029 SHALL, on rst, asynchronously force IDLE; ready=1; step_valid=0; step_p=0; res_valid=0; res_hit=0; res_dist=0; all tag valids=0; ray_* outputs=0.
REQ-030 SHALL, on rst mid-ray, abort the ray and produce no res_valid for it.

Configuration
REQ-031 SHALL, with macro RAY_MARCH_STATS_EN defined, add output res_steps (11 bits): the count of steps issued for the reported ray, valid with res_valid and cleared on accept.
REQ-032 SHALL, without RAY_MARCH_STATS_EN, have no res_steps port and no counter logic.

Structure
REQ-033 SHALL place in shared package ray_pkg: the state enum, P_W=19, DIST_W=10, DIST_MISS=10'h3FF, and the ori/dir widths.
REQ-034 SHALL implement the tag pipeline as sub-module ray_tag_pipe (depth L; shift, flush, empty outputs).

Verification (MAP_LAT=1, L=2)
REQ-035 SHALL cover: accept, hit asserted at T+1+5+2 -> res_valid next cycle with res_hit=1, res_dist=5; step_valid low after the hit edge.
REQ-036 SHALL cover: accept, hit never asserted -> 1024 steps issued (0..1023), then DRAIN, then res_hit=0, res_dist=10'h3FF.
REQ-037 SHALL cover: hit at T+3 (step 0) -> res_dist=0, res_hit=1.
REQ-038 SHALL cover: res_ack held low 20 cycles with start=1 -> res_valid and result stable, ready=0; res_ack=1 -> ready=1 next cycle.
REQ-039 SHALL cover: rst at step_p=100 -> step_valid=0 and ready=1 immediately, no res_valid; next ray starts at step_p=0.
REQ-040 SHALL cover: hit pulsed during IDLE and on the cycle after a new accept -> ignored; result is unaffected.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared types and widths for the ray-march controller.
package ray_pkg;

  localparam int P_W     = 19;  // step index width toward the position datapath
  localparam int DIST_W  = 10;  // live step / distance width
  localparam int ORI_W   = 11;  // signed origin component width
  localparam int DIR_W   = 10;  // signed direction component width (scaled by 2^8)
  localparam int STEPS_W = 11;  // issued-step counter width (up to 1024)

  localparam logic [DIST_W-1:0] DIST_MISS = 10'h3FF;

  // Controller states, also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ray_tag_pipe.sv
// Tag pipeline: a (valid, step index) shift register whose depth matches the
// sample-to-hit loop latency, so the tag at the output lines up with the hit
// input. Flush drops every in-flight tag, including the one being pushed.
module ray_tag_pipe
  import ray_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = DIST_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             flush,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             empty
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  // Shift every cycle; flush clears all valid bits in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_q[i] <= flush ? 1'b0 : vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      vld_q[0] <= in_valid & ~flush;
      idx_q[0] <= in_idx;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];
  assign empty     = ~|vld_q;

endmodule

// File: rtl/ray_march_ctrl.sv
// Ray-march step controller: accepts a ray, issues step indices to the
// position datapath, matches returning wall hits against a tag pipeline and
// reports the first hit distance (or a miss).
// Optional build macro RAY_MARCH_STATS_EN adds the res_steps counter output.
//
// Handshakes: a ray is accepted on a cycle where start && ready; ready is high
// only in IDLE. A result is presented with res_valid and held stable until a
// cycle with res_valid && res_ack, after which the controller returns to IDLE.
module ray_march_ctrl
  import ray_pkg::*;
#(
  parameter int MAX_STEP = 1023,
  parameter int MAP_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     ready,
  input  logic signed [ORI_W-1:0]  ori_x,
  input  logic signed [ORI_W-1:0]  ori_y,
  input  logic signed [ORI_W-1:0]  ori_z,
  input  logic signed [DIR_W-1:0]  dir_x,
  input  logic signed [DIR_W-1:0]  dir_y,
  input  logic signed [DIR_W-1:0]  dir_z,
  output logic signed [ORI_W-1:0]  ray_ori_x,
  output logic signed [ORI_W-1:0]  ray_ori_y,
  output logic signed [ORI_W-1:0]  ray_ori_z,
  output logic signed [DIR_W-1:0]  ray_dir_x,
  output logic signed [DIR_W-1:0]  ray_dir_y,
  output logic signed [DIR_W-1:0]  ray_dir_z,
  output logic [P_W-1:0]           step_p,
  output logic                     step_valid,
  input  logic                     hit,
  output logic                     res_valid,
  input  logic                     res_ack,
  output logic                     res_hit,
  output logic [DIST_W-1:0]        res_dist,
`ifdef RAY_MARCH_STATS_EN
  output logic [STEPS_W-1:0]       res_steps,
`endif
  output state_t                   dbg_state
);

  localparam int                L        = 1 + MAP_LAT;
  localparam logic [DIST_W-1:0] LAST_IDX = DIST_W'(MAX_STEP);

  state_t              state_q, state_d;
  logic [DIST_W-1:0]   step_q, step_d;
  logic                sv_q, sv_d;
  logic                res_hit_q, res_hit_d;
  logic [DIST_W-1:0]   res_dist_q, res_dist_d;
  logic                latch, push, flush;
  logic                tag_valid, tag_empty, hit_take;
  logic [DIST_W-1:0]   tag_idx;

  ray_tag_pipe #(
    .DEPTH (L),
    .IDX_W (DIST_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_idx    (step_q),
    .flush     (flush),
    .out_valid (tag_valid),
    .out_idx   (tag_idx),
    .empty     (tag_empty)
  );

  // A hit only counts when it lines up with a live tag while marching.
  assign hit_take = hit & tag_valid & ((state_q == ISSUE) || (state_q == DRAIN));

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      sv_q       <= 1'b0;
      res_hit_q  <= 1'b0;
      res_dist_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      sv_q       <= sv_d;
      res_hit_q  <= res_hit_d;
      res_dist_q <= res_dist_d;
    end
  end

  // Next-state and control: a taken hit beats end-of-issue and drops the
  // step issued in the same cycle.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    sv_d       = sv_q;
    res_hit_d  = res_hit_q;
    res_dist_d = res_dist_q;
    latch      = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          step_d  = '0;
          sv_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hit_take) begin
          flush      = 1'b1;
          res_hit_d  = 1'b1;
          res_dist_d = tag_idx;
          sv_d       = 1'b0;
          state_d    = DONE;
        end else begin
          push = 1'b1;
          if (step_q == LAST_IDX) begin
            sv_d    = 1'b0;
            state_d = DRAIN;
          end else begin
            step_d = step_q + 10'd1;
          end
        end
      end
      DRAIN: begin
        if (hit_take) begin
          flush      = 1'b1;
          res_hit_d  = 1'b1;
          res_dist_d = tag_idx;
          state_d    = DONE;
        end else if (tag_empty) begin
          res_hit_d  = 1'b0;
          res_dist_d = DIST_MISS;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (res_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ray geometry is captured on accept and held for the position datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ray_ori_x <= '0;
      ray_ori_y <= '0;
      ray_ori_z <= '0;
      ray_dir_x <= '0;
      ray_dir_y <= '0;
      ray_dir_z <= '0;
    end else if (latch) begin
      ray_ori_x <= ori_x;
      ray_ori_y <= ori_y;
      ray_ori_z <= ori_z;
      ray_dir_x <= dir_x;
      ray_dir_y <= dir_y;
      ray_dir_z <= dir_z;
    end
  end

`ifdef RAY_MARCH_STATS_EN
  logic [STEPS_W-1:0] steps_q;

  // Count every cycle a step is driven for the current ray.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps_q <= '0;
    end else if (latch) begin
      steps_q <= '0;
    end else if (state_q == ISSUE) begin
      steps_q <= steps_q + 11'd1;
    end
  end

  assign res_steps = steps_q;
`endif

  assign ready      = (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign step_valid = sv_q;
  assign step_p     = {{(P_W - DIST_W){1'b0}}, step_q};
  assign res_hit    = res_hit_q;
  assign res_dist   = res_dist_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Bench for ray_march_ctrl (MAX_STEP=1023, MAP_LAT=1, loop latency 2).
module tb_ray_march_ctrl;
  import ray_pkg::*;

  localparam int M = 1023;

  logic                     clk, rst, start, ready, hit;
  logic signed [ORI_W-1:0]  ori_x, ori_y, ori_z;
  logic signed [DIR_W-1:0]  dir_x, dir_y, dir_z;
  logic signed [ORI_W-1:0]  ray_ori_x, ray_ori_y, ray_ori_z;
  logic signed [DIR_W-1:0]  ray_dir_x, ray_dir_y, ray_dir_z;
  logic [P_W-1:0]           step_p;
  logic                     step_valid, res_valid, res_ack, res_hit;
  logic [DIST_W-1:0]        res_dist;
  state_t                   dbg_state;
`ifdef RAY_MARCH_STATS_EN
  logic [STEPS_W-1:0]       res_steps;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected {res_hit, res_dist} per ray.
  logic [DIST_W:0] exp_q[$];

  // Expected latched geometry.
  logic signed [ORI_W-1:0] e_ox, e_oy, e_oz;
  logic signed [DIR_W-1:0] e_dx, e_dy, e_dz;

  typedef struct {
    int                k_target;
    int                pct;
    int                ack_delay;
    bit                noise;
    bit                exp_hit;
    logic [DIST_W-1:0] exp_dist;
  } vec_t;

  vec_t vecs[6];

  ray_march_ctrl #(
    .MAX_STEP (M),
    .MAP_LAT  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready      (ready),
    .ori_x      (ori_x),
    .ori_y      (ori_y),
    .ori_z      (ori_z),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .dir_z      (dir_z),
    .ray_ori_x  (ray_ori_x),
    .ray_ori_y  (ray_ori_y),
    .ray_ori_z  (ray_ori_z),
    .ray_dir_x  (ray_dir_x),
    .ray_dir_y  (ray_dir_y),
    .ray_dir_z  (ray_dir_z),
    .step_p     (step_p),
    .step_valid (step_valid),
    .hit        (hit),
    .res_valid  (res_valid),
    .res_ack    (res_ack),
    .res_hit    (res_hit),
    .res_dist   (res_dist),
`ifdef RAY_MARCH_STATS_EN
    .res_steps  (res_steps),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic scramble_geom();
    ori_x = ORI_W'($urandom);
    ori_y = ORI_W'($urandom);
    ori_z = ORI_W'($urandom);
    dir_x = DIR_W'($urandom);
    dir_y = DIR_W'($urandom);
    dir_z = DIR_W'($urandom);
  endtask

  // Drive one ray from accept through acknowledge. The model tracks the first
  // hit that falls in a step's return slot (accept + 3 + k, k in 0..M).
  task automatic run_ray(input int k_target, input int pct, input int ack_delay,
                         input bit noise, output logic obs_hit,
                         output logic [DIST_W-1:0] obs_dist);
    int first;
    int last_issue;
    bit exp_sv, exp_rv, h;
    logic [DIST_W:0] e;
    first = -1;
    check("ready_idle", ready, 1);
    scramble_geom();
    e_ox = ori_x; e_oy = ori_y; e_oz = ori_z;
    e_dx = dir_x; e_dy = dir_y; e_dz = dir_z;
    start = 1'b1;
    res_ack = 1'b0;
    hit = noise;
    tick();
    start = 1'b0;
    for (int d = 1; d < M + 10; d++) begin
      last_issue = (first >= 0 && 3 + first < 1 + M) ? 3 + first : 1 + M;
      exp_sv = (d <= last_issue);
      exp_rv = (first >= 0) ? (d >= 4 + first) : (d >= 5 + M);
      check("step_valid", step_valid, exp_sv);
      if (exp_sv) check("step_p", step_p, d - 1);
      check("res_valid", res_valid, exp_rv);
      check("ready_busy", ready, 0);
      if (exp_rv) break;
      if (noise && d < 3) h = 1'b1;
      else if (k_target >= 0 && d == 3 + k_target) h = 1'b1;
      else if (pct > 0) h = ($urandom_range(0, 99) < pct);
      else h = 1'b0;
      hit = h;
      scramble_geom();
      if (first < 0 && h && d >= 3 && d - 3 <= M) first = d - 3;
      tick();
    end
    exp_q.push_back((first >= 0) ? {1'b1, DIST_W'(first)} : {1'b0, DIST_MISS});
    obs_hit  = res_hit;
    obs_dist = res_dist;
    e = exp_q.pop_front();
    check("res_hit", res_hit, e[DIST_W]);
    check("res_dist", res_dist, e[DIST_W-1:0]);
    check("ray_ori_x", ray_ori_x, e_ox);
    check("ray_ori_y", ray_ori_y, e_oy);
    check("ray_ori_z", ray_ori_z, e_oz);
    check("ray_dir_x", ray_dir_x, e_dx);
    check("ray_dir_y", ray_dir_y, e_dy);
    check("ray_dir_z", ray_dir_z, e_dz);
    for (int i = 0; i < ack_delay; i++) begin
      start = 1'b1;
      res_ack = 1'b0;
      hit = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_hit", res_hit, e[DIST_W]);
      check("hold_dist", res_dist, e[DIST_W-1:0]);
      check("hold_ready", ready, 0);
      check("hold_step_valid", step_valid, 0);
    end
    start = 1'b0;
    res_ack = 1'b1;
    hit = 1'b0;
    tick();
    check("ack_ready", ready, 1);
    check("ack_valid", res_valid, 0);
    check("ack_step_valid", step_valid, 0);
    res_ack = 1'b0;
  endtask

  initial begin
    logic              oh;
    logic [DIST_W-1:0] od;

    // Directed rows: {k_target, pct, ack_delay, noise, exp_hit, exp_dist}.
    vecs[0] = '{5,    0, 0,  1'b1, 1'b1, 10'd5};
    vecs[1] = '{0,    0, 2,  1'b1, 1'b1, 10'd0};
    vecs[2] = '{-1,   0, 1,  1'b0, 1'b0, 10'h3FF};
    vecs[3] = '{37,   0, 20, 1'b1, 1'b1, 10'd37};
    vecs[4] = '{1023, 0, 0,  1'b0, 1'b1, 10'd1023};
    vecs[5] = '{1,    0, 0,  1'b1, 1'b1, 10'd1};

    rst = 1'b1; start = 1'b0; hit = 1'b0; res_ack = 1'b0;
    ori_x = '0; ori_y = '0; ori_z = '0; dir_x = '0; dir_y = '0; dir_z = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_step_valid", step_valid, 0);
    check("rst_step_p", step_p, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_hit", res_hit, 0);
    check("rst_res_dist", res_dist, 0);
    check("rst_ray_ori_x", ray_ori_x, 0);
    check("rst_ray_dir_z", ray_dir_z, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    tick();

    // Hits while idle must not start or disturb anything.
    for (int i = 0; i < 4; i++) begin
      hit = 1'b1;
      tick();
      check("idle_hit_valid", res_valid, 0);
      check("idle_hit_step_valid", step_valid, 0);
    end
    hit = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_ray(vecs[i].k_target, vecs[i].pct, vecs[i].ack_delay, vecs[i].noise, oh, od);
      check("vec_hit", oh, vecs[i].exp_hit);
      check("vec_dist", od, vecs[i].exp_dist);
    end

    // Reset in the middle of a ray aborts it without a result.
    check("pre_rst_ready", ready, 1);
    scramble_geom();
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    repeat (100) tick();
    check("mid_step_p", step_p, 100);
    check("mid_step_valid", step_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_step_valid", step_valid, 0);
    check("arst_ready", ready, 1);
    check("arst_res_valid", res_valid, 0);
    check("arst_step_p", step_p, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hit = 1'($urandom_range(0, 1));
      tick();
      check("post_rst_valid", res_valid, 0);
      check("post_rst_ready", ready, 1);
      check("post_rst_step_valid", step_valid, 0);
    end
    hit = 1'b0;
    run_ray(5, 0, 0, 1'b1, oh, od);
    check("post_rst_dist", od, 10'd5);

    // Randomised rays against the model, mostly back-to-back.
    for (int i = 0; i < 25; i++) begin
      run_ray(-1, int'($urandom_range(1, 8)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), oh, od);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
